// File: rtl/aes_round_key_store.sv
// Multi-slot AES round-key store.
// Holds one round-key schedule per slot and returns keys in cipher order or in reversed (decipher) order.
// A per-slot valid flag and round count are set only when a schedule has been written in full.
module aes_round_key_store #(
    parameter int unsigned KEY_W      = 128,
    parameter int unsigned MAX_ROUNDS = 14,
    parameter int unsigned NUM_SLOTS  = 2,
    localparam int unsigned SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // write side, driven by the key-expansion unit
    input  logic                 wr_start,
    input  logic [SLOT_W-1:0]    wr_slot,
    input  logic [3:0]           wr_rounds,
    input  logic                 wr_valid,
    input  logic [KEY_W-1:0]     wr_key,
    input  logic                 wr_abort,
    output logic                 wr_ready,
    output logic                 wr_done,
    output logic                 wr_err,
    // read side, driven by the round datapath
    input  logic                 rd_req,
    input  logic [SLOT_W-1:0]    rd_slot,
    input  logic                 rd_dec,
    input  logic [3:0]           rd_round,
    output logic [KEY_W-1:0]     rd_key,
    output logic                 rd_valid,
    output logic                 rd_err,
    output logic [NUM_SLOTS-1:0] slot_valid
);

    localparam int unsigned DEPTH = MAX_ROUNDS + 1;
    localparam int unsigned RND_W = 4;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t                 state;
    logic [SLOT_W-1:0]      cur_slot;
    logic [RND_W-1:0]       cur_rounds;
    logic [RND_W-1:0]       ptr;
    logic [RND_W-1:0]       slot_rounds [NUM_SLOTS];
    logic [KEY_W-1:0]       mem [NUM_SLOTS][DEPTH];

    logic                   start_ok_c;
    logic                   wr_fire_c;
    logic [SLOT_W-1:0]      rd_idx_c;
    logic [RND_W-1:0]       rd_rounds_c;
    logic                   rd_err_c;
    logic [RND_W-1:0]       rd_phys_c;

    // Start is legal only for a supported round count that fits the slot depth, on an existing slot
    always_comb begin
        start_ok_c = 1'b0;
        if ((wr_rounds == 4'd10 || wr_rounds == 4'd12 || wr_rounds == 4'd14) &&
            (32'(wr_rounds) <= MAX_ROUNDS) &&
            (32'(wr_slot) < NUM_SLOTS)) begin
            start_ok_c = 1'b1;
        end
    end

    // A beat is written only while filling and only when abort is not asserted in the same cycle
    always_comb begin
        wr_fire_c = 1'b0;
        if (state == FILL && wr_valid && !wr_abort) begin
            wr_fire_c = 1'b1;
        end
    end

    // Fill state machine with slot valid tracking and registered write-side strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_slot   <= '0;
            cur_rounds <= '0;
            ptr        <= '0;
            slot_valid <= '0;
            wr_ready   <= 1'b0;
            wr_done    <= 1'b0;
            wr_err     <= 1'b0;
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                slot_rounds[s] <= '0;
            end
        end else begin
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_start) begin
                        if (start_ok_c) begin
                            cur_slot             <= wr_slot;
                            cur_rounds           <= wr_rounds;
                            ptr                  <= '0;
                            slot_valid[wr_slot]  <= 1'b0;
                            wr_ready             <= 1'b1;
                            state                <= FILL;
                        end else begin
                            wr_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (wr_abort) begin
                        wr_ready <= 1'b0;
                        state    <= IDLE;
                    end else if (wr_valid) begin
                        if (ptr == cur_rounds) begin
                            slot_valid[cur_slot]  <= 1'b1;
                            slot_rounds[cur_slot] <= cur_rounds;
                            wr_done               <= 1'b1;
                            wr_ready              <= 1'b0;
                            state                 <= IDLE;
                        end else begin
                            ptr <= ptr + RND_W'(1);
                        end
                    end
                end
                default: begin
                    wr_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Key storage; contents survive reset, only the valid flags are cleared
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire_c) begin
            mem[cur_slot][ptr] <= wr_key;
        end
    end

    // Read lookup: error checks first, and the reversed index is formed only once the round is in range
    always_comb begin
        rd_idx_c    = '0;
        rd_rounds_c = '0;
        rd_err_c    = 1'b1;
        rd_phys_c   = '0;
        if (32'(rd_slot) < NUM_SLOTS) begin
            rd_idx_c    = rd_slot;
            rd_rounds_c = slot_rounds[rd_slot];
            if (slot_valid[rd_slot] && (rd_round <= rd_rounds_c)) begin
                rd_err_c  = 1'b0;
                rd_phys_c = rd_dec ? (rd_rounds_c - rd_round) : rd_round;
            end
        end
    end

    // Registered read response; key holds its value between requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_req) begin
            rd_valid <= 1'b1;
            rd_err   <= rd_err_c;
            rd_key   <= rd_err_c ? '0 : mem[rd_idx_c][rd_phys_c];
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed self-checking bench for aes_round_key_store.
module tb_aes_round_key_store;

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned SLOT_W = 1;

    logic               clk;
    logic               rst_n;
    logic               wr_start;
    logic [SLOT_W-1:0]  wr_slot;
    logic [3:0]         wr_rounds;
    logic               wr_valid;
    logic [KEY_W-1:0]   wr_key;
    logic               wr_abort;
    logic               wr_ready;
    logic               wr_done;
    logic               wr_err;
    logic               rd_req;
    logic [SLOT_W-1:0]  rd_slot;
    logic               rd_dec;
    logic [3:0]         rd_round;
    logic [KEY_W-1:0]   rd_key;
    logic               rd_valid;
    logic               rd_err;
    logic [1:0]         slot_valid;

    int n_checks = 0;
    int n_fail   = 0;

    aes_round_key_store #(
        .KEY_W      (KEY_W),
        .MAX_ROUNDS (14),
        .NUM_SLOTS  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_start   (wr_start),
        .wr_slot    (wr_slot),
        .wr_rounds  (wr_rounds),
        .wr_valid   (wr_valid),
        .wr_key     (wr_key),
        .wr_abort   (wr_abort),
        .wr_ready   (wr_ready),
        .wr_done    (wr_done),
        .wr_err     (wr_err),
        .rd_req     (rd_req),
        .rd_slot    (rd_slot),
        .rd_dec     (rd_dec),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .slot_valid (slot_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Fill a slot with keys base+i; optional idle gaps between beats
    task automatic fill(input logic [SLOT_W-1:0] slot, input logic [3:0] rounds,
                        input int base, input bit gaps);
        wr_start = 1'b1; wr_slot = slot; wr_rounds = rounds;
        tick;
        wr_start = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ready slot=%0d got=%b exp=1", slot, wr_ready);
        end
        for (int i = 0; i <= int'(rounds); i++) begin
            wr_valid = 1'b1; wr_key = KEY_W'(base + i);
            tick;
            wr_valid = 1'b0;
            n_checks++;
            if (wr_done !== 1'(i == int'(rounds))) begin
                n_fail++;
                $display("FAIL fill_done beat=%0d got=%b exp=%b", i, wr_done, (i == int'(rounds)));
            end
            if (gaps && (i % 3 == 1)) begin
                tick;
                tick;
            end
        end
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ready_end got=%b exp=0", wr_ready);
        end
        tick;
        n_checks++;
        if (wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done_pulse got=%b exp=0", wr_done);
        end
    endtask

    // Single read request followed by a check of the registered response
    task automatic rd(input logic [SLOT_W-1:0] slot, input logic dec, input logic [3:0] round,
                      input logic exp_err, input logic [KEY_W-1:0] exp_key);
        rd_req = 1'b1; rd_slot = slot; rd_dec = dec; rd_round = round;
        tick;
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_err !== exp_err || rd_key !== exp_key) begin
            n_fail++;
            $display("FAIL read s%0d d%0d r%0d got v=%b e=%b k=%h exp v=1 e=%b k=%h",
                     slot, dec, round, rd_valid, rd_err, rd_key, exp_err, exp_key);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_checks++;
        if (wr_ready !== 1'b0 || wr_done !== 1'b0 || wr_err !== 1'b0 ||
            rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== '0 || slot_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b dn=%b we=%b rv=%b re=%b k=%h sv=%b exp all 0",
                     wr_ready, wr_done, wr_err, rd_valid, rd_err, rd_key, slot_valid);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fill_basic;
        fill(1'b0, 4'd10, 0, 1'b0);
        n_checks++;
        if (slot_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_slot_valid got=%b exp=01", slot_valid);
        end
        rd(1'b0, 1'b0, 4'd3, 1'b0, KEY_W'(3));
        rd(1'b0, 1'b1, 4'd0, 1'b0, KEY_W'(10));
        tick;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== KEY_W'(10)) begin
            n_fail++;
            $display("FAIL read_idle_hold got v=%b e=%b k=%h exp v=0 e=0 k=a", rd_valid, rd_err, rd_key);
        end
    endtask

    task automatic test_fill_gaps;
        fill(1'b1, 4'd14, 'h100, 1'b1);
        n_checks++;
        if (slot_valid !== 2'b11) begin
            n_fail++;
            $display("FAIL gaps_slot_valid got=%b exp=11", slot_valid);
        end
        rd(1'b1, 1'b1, 4'd14, 1'b0, KEY_W'('h100));
        rd(1'b1, 1'b0, 4'd14, 1'b0, KEY_W'('h10E));
        rd(1'b0, 1'b0, 4'd7, 1'b0, KEY_W'(7));
    endtask

    task automatic test_bad_start;
        wr_start = 1'b1; wr_slot = 1'b0; wr_rounds = 4'd11;
        tick;
        wr_start = 1'b0;
        n_checks++;
        if (wr_err !== 1'b1 || wr_ready !== 1'b0 || slot_valid !== 2'b11) begin
            n_fail++;
            $display("FAIL bad_start got err=%b rdy=%b sv=%b exp err=1 rdy=0 sv=11", wr_err, wr_ready, slot_valid);
        end
        tick;
        n_checks++;
        if (wr_err !== 1'b0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_start_pulse got err=%b rdy=%b exp 0 0", wr_err, wr_ready);
        end
    endtask

    task automatic test_round_range;
        rd(1'b0, 1'b0, 4'd11, 1'b1, '0);
        rd(1'b0, 1'b1, 4'd10, 1'b0, KEY_W'(0));
        rd(1'b0, 1'b1, 4'd15, 1'b1, '0);
    endtask

    task automatic test_abort;
        wr_start = 1'b1; wr_slot = 1'b0; wr_rounds = 4'd10;
        tick;
        wr_start = 1'b0;
        n_checks++;
        if (slot_valid !== 2'b10 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_invalidate got sv=%b rdy=%b exp sv=10 rdy=1", slot_valid, wr_ready);
        end
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_key = KEY_W'('hAA + i);
            if (i == 2) begin
                rd_req = 1'b1; rd_slot = 1'b1; rd_dec = 1'b0; rd_round = 4'd5;
            end
            if (i == 3) begin
                wr_start = 1'b1; wr_slot = 1'b1; wr_rounds = 4'd12;
            end
            tick;
            rd_req = 1'b0; wr_start = 1'b0;
            if (i == 2) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_key !== KEY_W'('h105)) begin
                    n_fail++;
                    $display("FAIL read_during_fill got v=%b e=%b k=%h exp v=1 e=0 k=105", rd_valid, rd_err, rd_key);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (wr_err !== 1'b0 || wr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_in_fill got err=%b rdy=%b exp err=0 rdy=1", wr_err, wr_ready);
                end
            end
        end
        wr_valid = 1'b1; wr_abort = 1'b1; wr_key = KEY_W'('hDEAD);
        tick;
        wr_valid = 1'b0; wr_abort = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b0 || wr_done !== 1'b0 || slot_valid !== 2'b10) begin
            n_fail++;
            $display("FAIL abort got rdy=%b dn=%b sv=%b exp rdy=0 dn=0 sv=10", wr_ready, wr_done, slot_valid);
        end
        rd(1'b0, 1'b0, 4'd3, 1'b1, '0);
    endtask

    task automatic test_same_cycle;
        wr_start = 1'b1; wr_slot = 1'b0; wr_rounds = 4'd12;
        tick;
        wr_start = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            wr_valid = 1'b1; wr_key = KEY_W'('h200 + i);
            if (i == 12) begin
                rd_req = 1'b1; rd_slot = 1'b0; rd_dec = 1'b0; rd_round = 4'd0;
            end
            tick;
            wr_valid = 1'b0; rd_req = 1'b0;
        end
        n_checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_key !== '0 || wr_done !== 1'b1 || slot_valid !== 2'b11) begin
            n_fail++;
            $display("FAIL same_cycle got v=%b e=%b k=%h dn=%b sv=%b exp v=1 e=1 k=0 dn=1 sv=11",
                     rd_valid, rd_err, rd_key, wr_done, slot_valid);
        end
        rd(1'b0, 1'b1, 4'd12, 1'b0, KEY_W'('h200));
        rd(1'b0, 1'b0, 4'd12, 1'b0, KEY_W'('h20C));
    endtask

    task automatic test_back_to_back;
        rd_req = 1'b1; rd_slot = 1'b1; rd_dec = 1'b0; rd_round = 4'd0;
        tick;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_key !== KEY_W'('h100)) begin
            n_fail++;
            $display("FAIL b2b_first got v=%b e=%b k=%h exp v=1 e=0 k=100", rd_valid, rd_err, rd_key);
        end
        rd_slot = 1'b0; rd_dec = 1'b1; rd_round = 4'd1;
        tick;
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_key !== KEY_W'('h20B)) begin
            n_fail++;
            $display("FAIL b2b_second got v=%b e=%b k=%h exp v=1 e=0 k=20b", rd_valid, rd_err, rd_key);
        end
        tick;
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end got v=%b exp v=0", rd_valid);
        end
    endtask

    task automatic test_reset_mid_fill;
        wr_start = 1'b1; wr_slot = 1'b1; wr_rounds = 4'd10;
        tick;
        wr_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_key = KEY_W'('h400 + i);
            tick;
        end
        rd_req = 1'b1; rd_slot = 1'b0; rd_dec = 1'b0; rd_round = 4'd2;
        rst_n = 1'b0;
        tick;
        wr_valid = 1'b0; rd_req = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b0 || wr_done !== 1'b0 || wr_err !== 1'b0 ||
            rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== '0 || slot_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_fill got rdy=%b dn=%b we=%b rv=%b re=%b k=%h sv=%b exp all 0",
                     wr_ready, wr_done, wr_err, rd_valid, rd_err, rd_key, slot_valid);
        end
        rst_n = 1'b1;
        tick;
        rd(1'b1, 1'b0, 4'd0, 1'b1, '0);
        fill(1'b1, 4'd10, 'h300, 1'b0);
        n_checks++;
        if (slot_valid !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_valid got=%b exp=10", slot_valid);
        end
        rd(1'b1, 1'b1, 4'd10, 1'b0, KEY_W'('h300));
        rd(1'b1, 1'b0, 4'd10, 1'b0, KEY_W'('h30A));
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_start  = 1'b0;
        wr_slot   = '0;
        wr_rounds = '0;
        wr_valid  = 1'b0;
        wr_key    = '0;
        wr_abort  = 1'b0;
        rd_req    = 1'b0;
        rd_slot   = '0;
        rd_dec    = 1'b0;
        rd_round  = '0;

        test_reset;
        test_fill_basic;
        test_fill_gaps;
        test_bad_start;
        test_round_range;
        test_abort;
        test_same_cycle;
        test_back_to_back;
        test_reset_mid_fill;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Parametrised multi-slot round-key memory for the AES datapath; successor to the single-context decipher key memory.
- Stores complete round-key schedules for NUM_SLOTS independent key contexts, each tagged with its own round count (10/12/14 for AES-128/192/256).
- Serves forward (cipher) or reversed (decipher) round order from the same storage.
- Sits between the key-expansion unit (write side) and the round datapath (read side), with a per-slot fill state machine, valid tracking and registered, error-checked reads.

Parameters:
- KEY_W, 128, width of one round key in bits.
- MAX_ROUNDS, 14, largest supported round count; each slot holds MAX_ROUNDS+1 keys; must be <= 15.
- NUM_SLOTS, 2, number of independent key contexts; SLOT_W = max(1, clog2(NUM_SLOTS)).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset is synchronous and active-low.
- wr_start  in  1  begin filling a slot; sampled only in IDLE.
- wr_slot  in  SLOT_W  slot to fill, sampled with wr_start.
- wr_rounds  in  4  round count for the schedule, sampled with wr_start.
- wr_valid  in  1  wr_key carries the next round key, index 0 first.
- wr_key  in  KEY_W  round key data.
- wr_abort  in  1  abandon the current fill.
- wr_ready  out  1  high while in FILL, meaning wr_valid is accepted.
- wr_done  out  1  one-cycle pulse when the final key of a schedule is written.
- wr_err  out  1  one-cycle pulse when wr_start is rejected.
- rd_req  in  1  read request.
- rd_slot  in  SLOT_W  slot to read.
- rd_dec  in  1  0 = cipher order, 1 = decipher (reversed) order.
- rd_round  in  4  logical round index.
- rd_key  out  KEY_W  registered read data.
- rd_valid  out  1  read response strobe.
- rd_err  out  1  read response error.
- slot_valid  out  NUM_SLOTS  per-slot complete-schedule flags.

Behaviour:
- Reset (rst_n low at an edge): state returns to IDLE, write pointer = 0, slot_valid = 0, and all stored round counts are cleared. rd_key = 0; rd_valid, rd_err, wr_ready, wr_done and wr_err are all 0. Memory contents are not cleared.
- Reset mid-fill: the fill is lost, and that slot stays invalid after reset.
- FSM states are IDLE and FILL.
- IDLE, on wr_start:
  - wr_rounds not in {10, 12, 14}, wr_rounds > MAX_ROUNDS, or wr_slot >= NUM_SLOTS: pulse wr_err next cycle and stay in IDLE.
  - Otherwise: latch slot and rounds, clear slot_valid[slot], set ptr = 0, and go to FILL.
- FILL:
  - wr_ready = 1. Each wr_valid writes wr_key to mem[slot][ptr] and increments ptr.
  - When wr_valid is accepted with ptr == rounds: set slot_valid[slot], store rounds for that slot, pulse wr_done, return to IDLE.
  - A full schedule therefore takes rounds+1 accepted beats; gaps in wr_valid are allowed.
  - wr_start is ignored in FILL.
  - wr_abort: return to IDLE without writing that cycle; the slot stays invalid.
  - wr_abort and wr_valid in the same cycle: abort wins and the key is not written.
- Read:
  - rd_req sampled at edge N; rd_valid = 1 at N+1 for exactly one cycle per request. Back-to-back requests are allowed, one per cycle.
  - Physical index = rd_dec ? (slot_rounds - rd_round) : rd_round.
  - Error when rd_slot >= NUM_SLOTS, slot_valid[rd_slot] == 0 (evaluated before edge N), or rd_round > slot_rounds. On error: rd_err = 1 and rd_key = 0.
  - Otherwise: rd_err = 0 and rd_key = stored key.
  - When rd_req is low: rd_valid = 0, rd_err = 0, rd_key holds its previous value.
- Simultaneous events:
  - A read of the slot whose final key is written in the same cycle returns an error, because valid is not yet set.
  - A read of a different valid slot during a fill is unaffected.
  - Starting a fill on a valid slot invalidates it immediately; reads from the next cycle on error.
- Arithmetic: round indices are unsigned 4-bit. The subtraction is only performed after the rd_round <= slot_rounds check, so it never wraps.

Test Plan:
- Reset, fill slot 0 with rounds=10, keys K_i = i (11 beats) -> wr_done on beat 11, slot_valid = 01. Read (slot 0, dec 0, round 3) -> rd_key = 3 one cycle later. Read (dec 1, round 0) -> 10.
- Fill slot 1 with rounds=14, keys 0x100+i, with idle gaps in wr_valid -> slot_valid = 11. Read (slot 1, dec 1, round 14) -> 0x100. Read (slot 1, dec 0, round 14) -> 0x10E. Slot 0 reads unchanged.
- wr_start with wr_rounds = 11 -> wr_err pulse, wr_ready stays 0, slot_valid unchanged.
- Start a refill of slot 0, write 5 keys, assert wr_abort -> IDLE, slot_valid[0] = 0, read of slot 0 gives rd_err = 1 with rd_key = 0.
- Slot 0 valid with rounds=10, read round 11 -> rd_err = 1. Read round 10 with dec = 1 -> key 0, rd_err = 0.
- Assert rst_n low mid-fill of slot 1 -> all outputs 0, slot_valid = 0, FSM in IDLE. A subsequent wr_start is accepted.
